// File: rtl/crypto_mmio.sv
// Bus-side register file and sequencer for the crypto region: key/plaintext/ctrl/status
// registers, TRNG key capture and aes10 launch/collect with a wait-state timeout.
module crypto_mmio #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [9:0]  trng_out,
    input  logic        trng_ready,
    output logic        aes_start,
    output logic [9:0]  aes_plaintext,
    output logic [9:0]  aes_key,
    input  logic [9:0]  aes_ciphertext,
    input  logic        aes_ready,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, KEY_WAIT, LAUNCH, DROP, WAIT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_reg, state_next;
    logic [9:0] key_reg, key_next;
    logic [9:0] plaintext_reg, plaintext_next;
    logic [9:0] result_reg, result_next;
    logic       key_valid_reg, key_valid_next;
    logic       ie_reg, ie_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic [7:0] cnt_reg, cnt_next;

    logic busy;
    logic hit_key, hit_data, hit_ctrl, hit_status;
    logic err_set, err_clr, done_set, done_clr;
    logic timed_out;

    // One-hot register select; the lowest set bit takes priority.
    assign hit_key    = addr[9] & addr[2];
    assign hit_data   = addr[9] & ~addr[2] & addr[3];
    assign hit_ctrl   = addr[9] & ~addr[2] & ~addr[3] & addr[4];
    assign hit_status = addr[9] & ~addr[2] & ~addr[3] & ~addr[4] & addr[5];

    assign busy      = (state_reg != IDLE);
    assign timed_out = (cnt_reg == TIMEOUT_CNT);

    always_comb begin
        state_next     = state_reg;
        key_next       = key_reg;
        plaintext_next = plaintext_reg;
        result_next    = result_reg;
        key_valid_next = key_valid_reg;
        ie_next        = ie_reg;
        err_set        = 1'b0;
        err_clr        = 1'b0;
        done_set       = 1'b0;
        done_clr       = 1'b0;

        if (we && hit_key) begin
            if (busy) begin
                err_set = 1'b1;
            end else if (wdata[31]) begin
                state_next = KEY_WAIT;
            end else begin
                key_next       = wdata[9:0];
                key_valid_next = 1'b1;
            end
        end
        if (we && hit_data) begin
            if (busy) err_set = 1'b1;
            else      plaintext_next = wdata[9:0];
        end
        if (we && hit_ctrl) begin
            ie_next = wdata[1];
            if (wdata[0]) begin
                if (busy || !key_valid_reg) begin
                    err_set = 1'b1;
                end else begin
                    state_next = LAUNCH;
                    done_clr   = 1'b1;
                end
            end
        end
        if (we && hit_status) begin
            done_clr = done_clr | wdata[0];
            err_clr  = wdata[3];
        end

        // Normal exits take precedence over a timeout landing on the same cycle.
        case (state_reg)
            KEY_WAIT: begin
                if (trng_ready) begin
                    key_next       = trng_out;
                    key_valid_next = 1'b1;
                    state_next     = IDLE;
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            LAUNCH: state_next = DROP;
            DROP: begin
                if (!aes_ready) begin
                    state_next = WAIT;
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (aes_ready) begin
                    result_next = aes_ciphertext;
                    done_set    = 1'b1;
                    state_next  = IDLE;
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: ;
        endcase

        done_next = done_set ? 1'b1 : (done_clr ? 1'b0 : done_reg);
        err_next  = err_set  ? 1'b1 : (err_clr  ? 1'b0 : err_reg);

        if (state_next != state_reg)
            cnt_next = 8'd0;
        else if (state_reg == KEY_WAIT || state_reg == DROP || state_reg == WAIT)
            cnt_next = cnt_reg + 8'd1;
        else
            cnt_next = cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            key_reg       <= '0;
            plaintext_reg <= '0;
            result_reg    <= '0;
            key_valid_reg <= 1'b0;
            ie_reg        <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            key_reg       <= key_next;
            plaintext_reg <= plaintext_next;
            result_reg    <= result_next;
            key_valid_reg <= key_valid_next;
            ie_reg        <= ie_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit_key)    rdata = {22'd0, key_reg};
        if (hit_data)   rdata = {22'd0, result_reg};
        if (hit_ctrl)   rdata = {30'd0, ie_reg, 1'b0};
        if (hit_status) rdata = {28'd0, err_reg, key_valid_reg, busy, done_reg};
    end

    // Reset gates the pulse combinationally so a run caught in LAUNCH never fires.
    assign aes_start     = (state_reg == LAUNCH) && !reset;
    assign aes_plaintext = plaintext_reg;
    assign aes_key       = key_reg;
    assign irq           = done_reg & ie_reg;

    logic unused_bits;
    assign unused_bits = ^{addr[31:10], addr[8:6], addr[1:0], wdata[30:10]};
endmodule
